// File: rtl/mouse_tracker.sv
// PS/2 3-byte mouse packet decoder with clamped cursor position accumulation.
// Produces registered cursor coordinates, button levels and click/packet/error pulses.
module mouse_tracker #(
    parameter int unsigned X_MAX          = 799,
    parameter int unsigned Y_MAX          = 599,
    parameter int unsigned X_INIT         = 400,
    parameter int unsigned Y_INIT         = 300,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [11:0] o_mouse_xpos,
    output logic [11:0] o_mouse_ypos,
    output logic        o_mouse_left,
    output logic        o_mouse_right,
    output logic        o_left_click,
    output logic        o_right_click,
    output logic        o_pkt_done,
    output logic        o_pkt_err
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [12:0] XMaxS = 13'(X_MAX);
    localparam logic signed [12:0] YMaxS = 13'(Y_MAX);

    typedef enum logic [1:0] {StB0, StB1, StB2} state_e;

    state_e          r_state, w_state_d;
    logic [TW-1:0]   r_timer, w_timer_d;
    // Header fields: {Yovf, Xovf, Ysign, Xsign, right, left}
    logic [5:0]      r_hdr, w_hdr_d;
    logic [7:0]      r_xbyte, w_xbyte_d;
    logic            w_apply;
    logic            w_err;

    logic [11:0]     r_xpos, r_ypos;
    logic            r_left, r_right;
    logic            r_left_click, r_right_click;
    logic            r_pkt_done, r_pkt_err;

    logic signed [12:0] w_dx, w_dy, w_nx, w_ny;
    logic [11:0]        w_xpos_new, w_ypos_new;

    // Middle button is deliberately ignored.
    logic w_unused;
    assign w_unused = i_rx_data[2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StB0;
            r_timer <= '0;
            r_hdr   <= '0;
            r_xbyte <= '0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_hdr   <= w_hdr_d;
            r_xbyte <= w_xbyte_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_hdr_d   = r_hdr;
        w_xbyte_d = r_xbyte;
        w_apply   = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            StB0: begin
                w_timer_d = '0;
                if (i_rx_valid) begin
                    if (i_rx_data[3]) begin
                        w_hdr_d   = {i_rx_data[7:4], i_rx_data[1:0]};
                        w_state_d = StB1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            StB1, StB2: begin
                if (i_rx_valid) begin
                    w_timer_d = '0;
                    if (r_state == StB1) begin
                        w_xbyte_d = i_rx_data;
                        w_state_d = StB2;
                    end else begin
                        w_apply   = 1'b1;
                        w_state_d = StB0;
                    end
                end else if (r_timer == TimerLast) begin
                    w_timer_d = '0;
                    w_err     = 1'b1;
                    w_state_d = StB0;
                end else begin
                    w_timer_d = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_d = StB0;
                w_timer_d = '0;
            end
        endcase
    end

    // The Y byte is consumed straight from the bus in the apply cycle.
    always_comb begin
        w_dx = r_hdr[4] ? 13'sd0 : {{4{r_hdr[2]}}, r_hdr[2], r_xbyte};
        w_dy = r_hdr[5] ? 13'sd0 : {{4{r_hdr[3]}}, r_hdr[3], i_rx_data};
        w_nx = $signed({1'b0, r_xpos}) + w_dx;
        w_ny = $signed({1'b0, r_ypos}) - w_dy;

        if (w_nx < 13'sd0) begin
            w_xpos_new = '0;
        end else if (w_nx > XMaxS) begin
            w_xpos_new = 12'(X_MAX);
        end else begin
            w_xpos_new = w_nx[11:0];
        end

        if (w_ny < 13'sd0) begin
            w_ypos_new = '0;
        end else if (w_ny > YMaxS) begin
            w_ypos_new = 12'(Y_MAX);
        end else begin
            w_ypos_new = w_ny[11:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_xpos        <= 12'(X_INIT);
            r_ypos        <= 12'(Y_INIT);
            r_left        <= 1'b0;
            r_right       <= 1'b0;
            r_left_click  <= 1'b0;
            r_right_click <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_pkt_err     <= 1'b0;
        end else begin
            r_left_click  <= 1'b0;
            r_right_click <= 1'b0;
            r_pkt_done    <= w_apply;
            r_pkt_err     <= w_err;
            if (w_apply) begin
                r_xpos        <= w_xpos_new;
                r_ypos        <= w_ypos_new;
                r_left        <= r_hdr[0];
                r_right       <= r_hdr[1];
                r_left_click  <= r_hdr[0] & ~r_left;
                r_right_click <= r_hdr[1] & ~r_right;
            end
        end
    end

    assign o_mouse_xpos  = r_xpos;
    assign o_mouse_ypos  = r_ypos;
    assign o_mouse_left  = r_left;
    assign o_mouse_right = r_right;
    assign o_left_click  = r_left_click;
    assign o_right_click = r_right_click;
    assign o_pkt_done    = r_pkt_done;
    assign o_pkt_err     = r_pkt_err;

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed bench for mouse_tracker: packet decode, clamping, resync, timeout, overflow, reset.
// Uses a short timeout so expiry can be exercised within a few cycles.
module tb_mouse_tracker;

    localparam int unsigned Tmo = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] xpos, ypos;
    logic        m_left, m_right, l_click, r_click, pkt_done, pkt_err;

    int n_tests = 0;
    int n_fail  = 0;

    mouse_tracker #(
        .X_MAX          (799),
        .Y_MAX          (599),
        .X_INIT         (400),
        .Y_INIT         (300),
        .TIMEOUT_CYCLES (Tmo)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_mouse_xpos  (xpos),
        .o_mouse_ypos  (ypos),
        .o_mouse_left  (m_left),
        .o_mouse_right (m_right),
        .o_left_click  (l_click),
        .o_right_click (r_click),
        .o_pkt_done    (pkt_done),
        .o_pkt_err     (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the edge sampling byte2.
    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        rx_data  = b0;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_data  = b1;
        @(posedge clk); #1;
        rx_data  = b2;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_x", xpos, 400);
        check("rst_y", ypos, 300);
        check("rst_left", m_left, 0);
        check("rst_right", m_right, 0);
        check("rst_done", pkt_done, 0);
        check("rst_err", pkt_err, 0);

        send_pkt(8'h08, 8'h0A, 8'h05);
        check("p1_done", pkt_done, 1);
        check("p1_x", xpos, 410);
        check("p1_y", ypos, 295);
        check("p1_lclick", l_click, 0);
        tick();
        check("p1_done_off", pkt_done, 0);

        send_pkt(8'h19, 8'hF6, 8'h00);
        check("p2_x", xpos, 400);
        check("p2_y", ypos, 295);
        check("p2_left", m_left, 1);
        check("p2_lclick", l_click, 1);
        tick();
        check("p2_lclick_off", l_click, 0);
        send_pkt(8'h19, 8'hF6, 8'h00);
        check("p3_x", xpos, 390);
        check("p3_left", m_left, 1);
        check("p3_lclick", l_click, 0);

        // Walk x down to 5, then clamp at 0.
        send_pkt(8'h18, 8'h00, 8'h00);
        check("w1_x", xpos, 134);
        send_pkt(8'h18, 8'h7F, 8'h00);
        check("w2_x", xpos, 5);
        send_pkt(8'h18, 8'hEC, 8'h00);
        check("clamp_x0", xpos, 0);
        check("clamp_x0_left", m_left, 0);

        // Walk to (795, 2), then clamp at X_MAX and at y=0.
        send_pkt(8'h08, 8'hFF, 8'hFF);
        check("w3_y", ypos, 40);
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h08, 8'hFF, 8'h00);
        check("w4_x", xpos, 765);
        send_pkt(8'h08, 8'h1E, 8'h26);
        check("w5_x", xpos, 795);
        check("w5_y", ypos, 2);
        send_pkt(8'h08, 8'h64, 8'h00);
        check("clamp_xmax", xpos, 799);
        send_pkt(8'h08, 8'h00, 8'h0A);
        check("clamp_y0", ypos, 0);
        check("clamp_y0_x", xpos, 799);

        // Resync on a header byte without bit 3.
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("resync_err", pkt_err, 1);
        check("resync_done", pkt_done, 0);
        tick();
        check("resync_err_off", pkt_err, 0);
        send_pkt(8'h38, 8'hFB, 8'hFB);
        check("resync_x", xpos, 794);
        check("resync_y", ypos, 5);

        // Partial packet, then idle until expiry.
        rx_data  = 8'h08;
        rx_valid = 1'b1;
        tick();
        rx_data  = 8'h05;
        tick();
        rx_valid = 1'b0;
        repeat (Tmo - 1) tick();
        check("tmo_early", pkt_err, 0);
        tick();
        check("tmo_err", pkt_err, 1);
        check("tmo_x", xpos, 794);
        check("tmo_y", ypos, 5);
        tick();
        check("tmo_err_off", pkt_err, 0);
        send_pkt(8'h08, 8'h03, 8'h00);
        check("post_tmo_done", pkt_done, 1);
        check("post_tmo_x", xpos, 797);

        // Byte arriving in the expiry cycle is accepted.
        rx_data  = 8'h18;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (Tmo - 1) tick();
        rx_data  = 8'hFE;
        rx_valid = 1'b1;
        tick();
        check("race_err", pkt_err, 0);
        rx_data = 8'h00;
        tick();
        rx_valid = 1'b0;
        check("race_done", pkt_done, 1);
        check("race_x", xpos, 795);
        check("race_y", ypos, 5);

        // Overflow flags zero the deltas but buttons update.
        send_pkt(8'hCA, 8'hFF, 8'hFF);
        check("ovf_x", xpos, 795);
        check("ovf_y", ypos, 5);
        check("ovf_right", m_right, 1);
        check("ovf_rclick", r_click, 1);
        tick();
        check("ovf_rclick_off", r_click, 0);

        // Reset while waiting for byte2.
        rx_data  = 8'hCA;
        rx_valid = 1'b1;
        tick();
        rx_data = 8'hFF;
        tick();
        rx_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_x", xpos, 400);
        check("mrst_y", ypos, 300);
        check("mrst_right", m_right, 0);
        check("mrst_left", m_left, 0);
        send_pkt(8'h08, 8'h0A, 8'h05);
        check("mrst_pkt_x", xpos, 410);
        check("mrst_pkt_y", ypos, 295);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
